// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the FSM state encoding, the NOP word and instruction field slices.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    DRAIN
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int OPC_OP_LO = 0;
  localparam int OPC_OP_HI = 6;
  localparam int OPC_F3_LO = 12;
  localparam int OPC_F3_HI = 14;
  localparam int OPC_F7_LO = 25;
  localparam int OPC_F7_HI = 31;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle.
// master: req/addr out, rdata/valid in. slave: the memory side.
interface fetch_stage_if #(
  parameter int XLEN = 32
);
  logic            req;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] rdata;
  logic            valid;

  modport master (
    output req, addr,
    input  rdata, valid
  );

  modport slave (
    input  req, addr,
    output rdata, valid
  );
endinterface

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register with load, flush (NOP insert) and hold.
// Ports: clk, rst, load, flush, nxt_pc/nxt_instr in; pc, instr, valid and field slices out.
module ifid_reg
  import fetch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            flush,
  input  logic [XLEN-1:0] nxt_pc,
  input  logic [XLEN-1:0] nxt_instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instr,
  output logic            valid,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7
);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= '0;
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (flush) begin
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (load) begin
      pc    <= nxt_pc;
      instr <= nxt_instr;
      valid <= 1'b1;
    end
  end

  assign opcode = instr[OPC_OP_HI:OPC_OP_LO];
  assign funct3 = instr[OPC_F3_HI:OPC_F3_LO];
  assign funct7 = instr[OPC_F7_HI:OPC_F7_LO];

endmodule

// File: rtl/fetch_stage.sv
// RV32I fetch stage: PC, imem request FSM, redirect/drain, IF/ID feed.
// Ports: clk, rst, pc_en, stall, br_taken/br_target, imem (master), ifid_*, fields;
// fetch_misalign exists only when FETCH_MISALIGN_TRAP_EN is defined.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_en,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  fetch_stage_if.master   imem,
  output logic [XLEN-1:0] ifid_pc,
  output logic [XLEN-1:0] ifid_instr,
  output logic            ifid_valid,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic            fetch_misalign
`endif
);

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_nxt;
  logic [XLEN-1:0] hb_pc;
  logic [XLEN-1:0] hb_instr;
  logic [XLEN-1:0] tgt;
  logic            hs;
  logic            adv;
  logic            misal;
  logic            halt;
  logic            ld;
  logic            from_hb;

  assign hs     = imem.req & imem.valid;
  assign adv    = ~stall & pc_en;
  assign pc_nxt = pc + XLEN'(4);

`ifdef FETCH_MISALIGN_TRAP_EN
  logic trap;
  assign tgt            = br_target;
  assign misal          = |br_target[1:0];
  assign halt           = trap;
  assign fetch_misalign = trap;
`else
  // Low bits dropped: without the trap a redirect is always word-aligned.
  assign tgt   = br_target & ~XLEN'(3);
  assign misal = 1'b0;
  assign halt  = 1'b0;
`endif

  assign from_hb = (state == HOLD);
  assign ld = ~br_taken & adv &
              ((state == FETCH & hs) | from_hb);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      imem.req  <= 1'b0;
      imem.addr <= RESET_PC;
      hb_pc     <= '0;
      hb_instr  <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      trap      <= 1'b0;
`endif
    end else if (halt) begin
      state    <= IDLE;
      imem.req <= 1'b0;
    end else if (br_taken) begin
      pc       <= tgt;
      hb_pc    <= '0;
      hb_instr <= '0;
      if (misal) begin
        state     <= IDLE;
        imem.req  <= 1'b0;
        imem.addr <= tgt;
`ifdef FETCH_MISALIGN_TRAP_EN
        trap      <= 1'b1;
`endif
      end else if ((state == FETCH || state == DRAIN) && !hs) begin
        // Outstanding request must complete at its old address.
        state <= DRAIN;
      end else begin
        state     <= FETCH;
        imem.req  <= 1'b1;
        imem.addr <= tgt;
      end
    end else begin
      unique case (state)
        IDLE: begin
          state     <= FETCH;
          imem.req  <= 1'b1;
          imem.addr <= pc;
        end
        FETCH: begin
          if (hs && adv) begin
            pc        <= pc_nxt;
            imem.addr <= pc_nxt;
          end else if (hs) begin
            hb_pc    <= pc;
            hb_instr <= imem.rdata;
            state    <= HOLD;
            imem.req <= 1'b0;
          end
        end
        HOLD: begin
          if (adv) begin
            pc        <= pc_nxt;
            imem.addr <= pc_nxt;
            imem.req  <= 1'b1;
            state     <= FETCH;
          end
        end
        DRAIN: begin
          if (hs) begin
            state     <= FETCH;
            imem.req  <= 1'b1;
            imem.addr <= pc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  ifid_reg #(
    .XLEN(XLEN)
  ) u_ifid (
    .clk      (clk),
    .rst      (rst),
    .load     (ld),
    .flush    (br_taken),
    .nxt_pc   (from_hb ? hb_pc : pc),
    .nxt_instr(from_hb ? hb_instr : imem.rdata),
    .pc       (ifid_pc),
    .instr    (ifid_instr),
    .valid    (ifid_valid),
    .opcode   (opcode),
    .funct3   (funct3),
    .funct7   (funct7)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios plus random traffic.
// Expected program-order PCs are queued at each edge; a negedge monitor checks IF/ID.
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_en = 1'b1;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_misalign;
`endif

  fetch_stage_if #(.XLEN(32)) imem ();

  fetch_stage #(
    .XLEN    (32),
    .RESET_PC(32'h0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pc_en     (pc_en),
    .stall     (stall),
    .br_taken  (br_taken),
    .br_target (br_target),
    .imem      (imem),
    .ifid_pc   (ifid_pc),
    .ifid_instr(ifid_instr),
    .ifid_valid(ifid_valid),
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7    (funct7)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .fetch_misalign(fetch_misalign)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int n_dlv = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  // Memory responder state
  int wait_cnt = 0;
  int cur_lat = 1;
  int lat_cfg = 1;
  bit rnd_lat = 0;

  // Edge-sampled stimulus and reference program stream
  logic        hs_q = 0, adv_q = 1, br_q = 0, rst_q = 1, trap_q = 0;
  logic [31:0] exp_q[$];
  bit          halted = 0;

  always @(posedge clk) begin
    hs_q  = imem.req & imem.valid;
    adv_q = !stall && pc_en;
    br_q  = br_taken;
    rst_q = rst;
    trap_q = 1'b0;
    if (rst) begin
      exp_q.delete();
      exp_q.push_back(32'h0);
      halted = 0;
    end else if (br_taken && !halted) begin
      exp_q.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
      if (br_target[1:0] != 2'b00) begin
        halted = 1;
        trap_q = 1'b1;
      end else begin
        exp_q.push_back(br_target);
      end
`else
      exp_q.push_back({br_target[31:2], 2'b00});
`endif
    end
  end

  task automatic mem_update();
    if (rst_q || hs_q) begin
      wait_cnt = 0;
      cur_lat = rnd_lat ? int'($urandom_range(1, 3)) : lat_cfg;
    end
    if (imem.req) begin
      imem.valid = (wait_cnt + 1 >= cur_lat);
      wait_cnt++;
    end else begin
      imem.valid = 1'b0;
    end
    imem.rdata = mem_word(imem.addr);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    mem_update();
  endtask

  // Monitor
  logic        pv = 0, preq = 0, dlv;
  logic [31:0] ppc = 0, pins = 0, paddr = 0, e_pc, e_ins;

  always @(negedge clk) begin
    if (rst_q === 1'b0) begin
      dlv = ifid_valid && (!pv || ifid_pc != ppc || ifid_instr != pins);
      if (br_q) begin
        check("flush_valid", {31'b0, ifid_valid}, 32'd0);
        check("flush_nop", ifid_instr, NOP);
      end
      if (dlv) begin
        n_dlv++;
        check("load_gate", {31'b0, adv_q}, 32'd1);
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_load: got pc %h want none", ifid_pc);
        end else begin
          e_pc  = exp_q.pop_front();
          e_ins = mem_word(e_pc);
          check("ifid_pc", ifid_pc, e_pc);
          check("ifid_instr", ifid_instr, e_ins);
          check("opcode", {25'b0, opcode}, {25'b0, e_ins[6:0]});
          check("funct3", {29'b0, funct3}, {29'b0, e_ins[14:12]});
          check("funct7", {25'b0, funct7}, {25'b0, e_ins[31:25]});
          exp_q.push_back(e_pc + 32'd4);
        end
      end
      if (preq && !hs_q && !trap_q) begin
        check("req_held", {31'b0, imem.req}, 32'd1);
        check("addr_stable", imem.addr, paddr);
      end
    end
    pv    = ifid_valid;
    ppc   = ifid_pc;
    pins  = ifid_instr;
    preq  = imem.req;
    paddr = imem.addr;
  end

  task automatic do_reset();
    rst = 1'b1;
    stall = 1'b0;
    pc_en = 1'b1;
    br_taken = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    imem.valid = 1'b0;
    imem.rdata = '0;

    // Reset state
    lat_cfg = 1;
    do_reset();
    rst = 1'b1;
    tick();
    check("rst_valid", {31'b0, ifid_valid}, 32'd0);
    check("rst_instr", ifid_instr, NOP);
    check("rst_pc", ifid_pc, 32'd0);
    check("rst_req", {31'b0, imem.req}, 32'd0);
    check("rst_opcode", {25'b0, opcode}, 32'h13);
    check("rst_f3f7", {22'b0, funct3, funct7}, 32'd0);
    rst = 1'b0;

    // Zero-wait streaming
    for (int k = 0; k < 5; k++) begin
      tick();
      check("zw_addr", imem.addr, 32'(4 * k));
      check("zw_req", {31'b0, imem.req}, 32'd1);
      if (k >= 1) check("zw_ifid_pc", ifid_pc, 32'(4 * (k - 1)));
    end

    // 3-cycle memory
    lat_cfg = 3;
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      tick();
      check("lat3_addr", imem.addr, 32'(4 * ((k - 1) / 3)));
    end

    // Stall on handshake at 0x8
    lat_cfg = 1;
    do_reset();
    tick();
    tick();
    tick();
    check("st_pre_addr", imem.addr, 32'h8);
    stall = 1'b1;
    tick();
    check("st_hold_req", {31'b0, imem.req}, 32'd0);
    check("st_hold_pc", ifid_pc, 32'h4);
    tick();
    check("st_hold_req2", {31'b0, imem.req}, 32'd0);
    check("st_hold_pc2", ifid_pc, 32'h4);
    stall = 1'b0;
    tick();
    check("st_rel_pc", ifid_pc, 32'h8);
    check("st_rel_addr", imem.addr, 32'hC);

    // Redirect with a request outstanding at 0x10
    do_reset();
    for (int k = 0; k < 5; k++) tick();
    check("dr_addr", imem.addr, 32'h10);
    cur_lat = 4;
    imem.valid = 1'b0;
    br_taken = 1'b1;
    br_target = 32'h100;
    for (int k = 0; k < 8; k++) begin
      tick();
      br_taken = 1'b0;
      if (imem.addr != 32'h10) break;
      check("dr_req", {31'b0, imem.req}, 32'd1);
      check("dr_valid", {31'b0, ifid_valid}, 32'd0);
    end
    check("dr_new_addr", imem.addr, 32'h100);
    check("dr_gap_valid", {31'b0, ifid_valid}, 32'd0);
    tick();
    check("dr_first_pc", ifid_pc, 32'h100);

    // Redirect with stall and same-cycle handshake
    stall = 1'b1;
    br_taken = 1'b1;
    br_target = 32'h200;
    tick();
    stall = 1'b0;
    br_taken = 1'b0;
    check("bs_valid", {31'b0, ifid_valid}, 32'd0);
    check("bs_instr", ifid_instr, NOP);
    check("bs_addr", imem.addr, 32'h200);
    tick();
    check("bs_pc", ifid_pc, 32'h200);

    // Misaligned redirect
    br_taken = 1'b1;
    br_target = 32'h302;
    tick();
    br_taken = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int k = 0; k < 4; k++) begin
      check("mis_flag", {31'b0, fetch_misalign}, 32'd1);
      check("mis_req", {31'b0, imem.req}, 32'd0);
      tick();
    end
    do_reset();
    tick();
    check("mis_clear", {31'b0, fetch_misalign}, 32'd0);
`else
    check("mis_addr", imem.addr, 32'h300);
    tick();
    check("mis_pc", ifid_pc, 32'h300);
`endif

    // Random traffic
    do_reset();
    rnd_lat = 1;
    n_dlv = 0;
    for (int i = 0; i < 1500; i++) begin
      stall    = ($urandom_range(0, 3) == 0);
      pc_en    = ($urandom_range(0, 9) != 0);
      br_taken = ($urandom_range(0, 19) == 0);
      br_target = 32'h1000 + (32'($urandom_range(0, 1023)) << 2);
`ifndef FETCH_MISALIGN_TRAP_EN
      br_target[1:0] = 2'($urandom_range(0, 3));
`endif
      tick();
    end
    stall = 1'b0;
    br_taken = 1'b0;
    pc_en = 1'b1;
    tick();
    tick();
    check("rnd_progress", {31'b0, n_dlv > 200}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
